mbist_controller: RTL and testbench
===================================

Name: mbist_controller

Overview:
- March-style MBIST sequencer that sits directly upstream of the pattern decoder.
- Drives the 3-bit pattern selector `q` into the decoder and takes back the 8-bit background `data_t`.
- For each pattern it writes `data_t` to every memory address, then reads every address back and compares the result against `data_t`.
- Reports `done`, a sticky `fail` flag, and the address and pattern of the first miscompare.

Parameters:
- ADDR_W, 4, memory address width; DEPTH = 2**ADDR_W words.
- NUM_PAT, 6, number of decoder patterns exercised (q = 0 .. NUM_PAT-1); legal range is 1..6.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous active-high.
- start  input  1  level-sampled in IDLE/DONE; begins a test run.
- q  output  3  pattern selector to the decoder.
- data_t  input  8  background pattern returned by the decoder (combinational from q).
- mem_addr  output  ADDR_W  memory address.
- mem_we  output  1  memory write enable.
- mem_re  output  1  memory read enable.
- mem_wdata  output  8  write data; equals data_t.
- mem_rdata  input  8  synchronous read data, valid one cycle after mem_re.
- busy  output  1  high from the first WRITE cycle through FLUSH of the last pattern.
- done  output  1  run complete; held until the next accepted start.
- fail  output  1  sticky; set on any miscompare.
- fail_addr  output  ADDR_W  address of the first miscompare.
- fail_pat  output  3  q value at the first miscompare.

Behaviour:
- Reset values (rst high, asynchronous): state=IDLE, q=0, mem_addr=0, mem_we=0, mem_re=0, busy=0, done=0, fail=0, fail_addr=0, fail_pat=0.
- Reset asserted mid-run aborts the run immediately. No memory access occurs after rst rises.
- States:
  - IDLE: on start=1, clear done, fail, fail_addr and fail_pat; set q=0, addr=0; go to WRITE.
  - WRITE: mem_we=1, mem_wdata=data_t, addr increments every cycle. At addr=DEPTH-1, go to READ with addr=0.
  - READ: mem_re=1, addr increments every cycle. At addr=DEPTH-1, go to FLUSH.
  - FLUSH: one cycle with no memory access, used to compare the last read.
    - If q=NUM_PAT-1, go to DONE.
    - Otherwise q increments, addr=0, go to WRITE.
  - DONE: done=1, busy=0. start=1 begins a new run exactly as from IDLE.
- Compare pipeline:
  - A registered copy of (addr, re) is compared one cycle later, in the READ or FLUSH cycle.
  - The comparison is mem_rdata against data_t; q does not change until after FLUSH, so data_t is stable for the comparison.
- Miscompare handling:
  - On the first miscompare, fail=1 and fail_addr/fail_pat capture the delayed addr and the current q.
  - Later miscompares leave fail_addr/fail_pat unchanged.
  - The run always continues to DONE; there is no early abort.
- mem_we and mem_re are never high in the same cycle. Both are 0 in IDLE, FLUSH and DONE.
- start is ignored while busy.
- Timing: start sampled at edge 0.
  - The first WRITE cycle follows edge 0.
  - Each pattern takes 2*DEPTH+1 cycles.
  - done rises after NUM_PAT*(2*DEPTH+1) cycles, i.e. 198 cycles with the default parameters.
- Address counter: ADDR_W-bit. Wrap from DEPTH-1 to 0 occurs only at the WRITE→READ transition or via FLUSH, never by free overflow.

Test Plan:
- Reset, then start=1 for one cycle with an ideal memory model → q steps 0..5; each pattern has 16 writes then 16 reads; done=1 exactly 198 cycles after start; fail=0 throughout.
- Memory model forces bit 0 of address 5 stuck-at-1 → fail=1, fail_addr=5, fail_pat=0 (pattern 10101010 has bit 0 = 0). Later patterns with bit 0 = 0 still complete, capture stays unchanged, done still asserts at 198 cycles.
- Memory corrupts only address 15 under q=3 (00001111 read back as 00001110) → fail_addr=15, fail_pat=3. The compare is detected in the FLUSH cycle of pattern 3.
- Assert rst for one cycle at cycle 50 of a run → all outputs return to reset values asynchronously; no mem_we/mem_re until a new start; the new run completes in 198 cycles.
- Toggle start during the run → ignored (no restart, timing unchanged). start after done → done clears and the run repeats identically.
- Checker every cycle: mem_we & mem_re never both 1; mem_wdata equals the decoder pattern for q (q=2 → 11110000, q=5 → 11111111).

Source files
------------

// File: rtl/mbist_controller.sv
// mbist_controller: march-style write-all/read-all MBIST sequencer over NUM_PAT decoder backgrounds.
module mbist_controller #(
  parameter int ADDR_W  = 4,
  parameter int NUM_PAT = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [2:0]        q,
  input  logic [7:0]        data_t,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_pat
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_e;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [2:0] LAST_PAT = 3'(NUM_PAT - 1);
  state_e state_q, state_d;
  logic [2:0] q_q, q_d, fail_pat_q, fail_pat_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr_q, fail_addr_q, fail_addr_d;
  logic rd_v_q, fail_q, fail_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      q_q         <= '0;
      addr_q      <= '0;
      rd_addr_q   <= '0;
      rd_v_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_pat_q  <= '0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      addr_q      <= addr_d;
      rd_addr_q   <= addr_q;
      rd_v_q      <= state_q == READ;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_pat_q  <= fail_pat_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    addr_d      = addr_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_pat_d  = fail_pat_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d     = WRITE;
        q_d         = '0;
        addr_d      = '0;
        fail_d      = 1'b0;
        fail_addr_d = '0;
        fail_pat_d  = '0;
      end
      WRITE: begin
        addr_d  = addr_q == LAST_ADDR ? '0 : addr_q + 1'b1;
        state_d = addr_q == LAST_ADDR ? READ : WRITE;
      end
      READ: begin
        addr_d  = addr_q == LAST_ADDR ? '0 : addr_q + 1'b1;
        state_d = addr_q == LAST_ADDR ? FLUSH : READ;
      end
      FLUSH: begin
        addr_d  = '0;
        state_d = q_q == LAST_PAT ? DONE : WRITE;
        q_d     = q_q == LAST_PAT ? q_q : q_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
    // q only advances after FLUSH, so data_t still matches the read being compared
    if (rd_v_q && mem_rdata != data_t) begin
      fail_d      = 1'b1;
      fail_addr_d = fail_q ? fail_addr_q : rd_addr_q;
      fail_pat_d  = fail_q ? fail_pat_q : q_q;
    end
  end
  assign q         = q_q;
  assign mem_addr  = addr_q;
  assign mem_we    = state_q == WRITE;
  assign mem_re    = state_q == READ;
  assign mem_wdata = data_t;
  assign busy      = state_q == WRITE || state_q == READ || state_q == FLUSH;
  assign done      = state_q == DONE;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_pat  = fail_pat_q;
endmodule

// File: tb/tb_mbist_controller.sv
// tb_mbist_controller: directed and randomized fault runs against a cycle-level reference of the march sequence.
module tb_mbist_controller;
  logic clk = 1'b0, rst, start;
  logic [2:0] q, fail_pat;
  logic [7:0] data_t, mem_wdata, mem_rdata = 8'h00;
  logic [3:0] mem_addr, fail_addr;
  logic mem_we, mem_re, busy, done, fail;
  int n_assert = 0, n_fail = 0;
  logic s_en = 0, c_en = 0;
  logic [3:0] s_addr, c_addr;
  logic [7:0] s_mask, s_val, c_mask;
  int c_pat;
  logic [7:0] mem [16];

  mbist_controller dut (
    .clk(clk), .rst(rst), .start(start), .q(q), .data_t(data_t),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_pat(fail_pat)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int p);
    return p == 0 ? 8'hAA : p == 1 ? 8'h55 : p == 2 ? 8'hF0 :
           p == 3 ? 8'h0F : p == 4 ? 8'h00 : 8'hFF;
  endfunction

  // faulty cell behaviour seen on a read of address a while pattern p is active
  function automatic logic [7:0] rd_val(input int p, input int a, input logic [7:0] v);
    logic [7:0] r = v;
    if (s_en && a == int'(s_addr)) r = (r & ~s_mask) | (s_val & s_mask);
    if (c_en && a == int'(c_addr) && p == c_pat) r = r ^ c_mask;
    return r;
  endfunction

  assign data_t = pat(int'(q));

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= rd_val(int'(q), int'(mem_addr), mem[mem_addr]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {q, mem_addr, mem_we, mem_re, busy, done, fail, fail_addr, fail_pat}, 0);
  endtask

  // one run from start; toggle randomizes start while busy; abort >= 0 pulses rst in that cycle
  task automatic run(input bit toggle, input int abort);
    int ff = -1, ea = 0, ep = 0;
    for (int p = 0; p < 6 && ff < 0; p++)
      for (int a = 0; a < 16 && ff < 0; a++)
        if (rd_val(p, a, pat(p)) != pat(p)) begin
          ff = p * 33 + a + 18;
          ea = a;
          ep = p;
        end
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 198; j++) begin
      int p = j / 33, r = j % 33;
      bit we = r < 16, re = r >= 16 && r < 32;
      if (toggle) start = 1'($urandom_range(0, 1));
      chk("ctl", {q, mem_we, mem_re, busy, done}, {3'(p), we, re, 1'b1, 1'b0});
      if (we || re) chk("addr", mem_addr, we ? r : r - 16);
      chk("wdata", mem_wdata, pat(p));
      chk("excl", mem_we & mem_re, 0);
      chk("fail_run", fail, ff >= 0 && j >= ff);
      if (j == abort) begin
        #2 rst = 1'b1;
        #1 chk_reset("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done", {busy, done, mem_we, mem_re}, 4'b0100);
    chk("fail_end", {fail, fail_addr, fail_pat}, {ff >= 0, 4'(ea), 3'(ep)});
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("idle");
    run(0, -1);
    @(negedge clk);
    chk("done_hold", {done, busy}, 2'b10);
    run(1, -1);
    s_en = 1; s_addr = 5; s_mask = 8'h01; s_val = 8'h01;
    run(0, -1);
    s_en = 0;
    c_en = 1; c_addr = 15; c_pat = 3; c_mask = 8'h01;
    run(1, -1);
    c_en = 0;
    run(0, 50);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_abort", {mem_we, mem_re, busy, done}, 0);
    end
    run(0, -1);
    for (int t = 0; t < 5; t++) begin
      s_en = 1'($urandom_range(0, 1));
      s_addr = 4'($urandom_range(0, 15));
      s_mask = 8'(1 << $urandom_range(0, 7));
      s_val = 8'($urandom);
      c_en = 1'($urandom_range(0, 1));
      c_addr = 4'($urandom_range(0, 15));
      c_pat = $urandom_range(0, 5);
      c_mask = 8'($urandom_range(1, 255));
      run(1'(t & 1), -1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
